// File: rtl/program_loader.sv
// Program memory loader: streams 4-bit words into RAM from address 0
// and serves a ROM-compatible combinational fetch port.
module program_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [3:0]  NOP_WORD   = 4'b0111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startIn,
  input  logic [ADDR_WIDTH:0]   lengthIn,
  input  logic                  abortIn,
  input  logic                  dataValidIn,
  input  logic [3:0]            dataIn,
  output logic                  dataReadyOut,
  output logic                  loadingOut,
  output logic                  doneOut,
  output logic                  errorOut,
  output logic [ADDR_WIDTH:0]   wordCountOut,
  input  logic [ADDR_WIDTH-1:0] addressIn,
  output logic [3:0]            dataOut
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] ZERO_W  = '0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH:0] len_q, len_d;
  logic                err_q, err_d;
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [3:0]          mem_q [DEPTH];
  logic                we;
  logic [ADDR_WIDTH-1:0] ptr;

  // Word count doubles as the write pointer; it never exceeds DEPTH.
  assign ptr = cnt_q[ADDR_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
    vld_d   = vld_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (startIn) begin
          if (lengthIn > DEPTH_W) begin
            err_d = 1'b1;
          end else begin
            vld_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            len_d   = lengthIn;
            state_d = (lengthIn == ZERO_W) ? DONE : LOAD;
          end
        end
      end
      LOAD: begin
        // Abort wins over a simultaneous transfer.
        if (abortIn) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (dataValidIn) begin
          we         = 1'b1;
          vld_d[ptr] = 1'b1;
          cnt_d      = cnt_q + ONE_W;
          if (cnt_d == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[ptr] <= dataIn;
    end
  end

  assign dataReadyOut = (state_q == LOAD);
  assign loadingOut   = (state_q == LOAD);
  assign doneOut      = (state_q == DONE);
  assign errorOut     = err_q;
  assign wordCountOut = cnt_q;
  assign dataOut      = vld_q[addressIn] ? mem_q[addressIn] : NOP_WORD;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed load sessions
// plus a randomized phase compared against a behavioural model.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int AW = 4;
  localparam int D  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          startIn = 1'b0;
  logic [AW:0]   lengthIn = '0;
  logic          abortIn = 1'b0;
  logic          dataValidIn = 1'b0;
  logic [3:0]    dataIn = '0;
  logic [AW-1:0] addressIn = '0;
  logic          dataReadyOut, loadingOut, doneOut, errorOut;
  logic [AW:0]   wordCountOut;
  logic [3:0]    dataOut;

  program_loader #(.ADDR_WIDTH(AW), .NOP_WORD(4'b0111)) dut (
    .clk(clk), .reset(reset), .startIn(startIn), .lengthIn(lengthIn),
    .abortIn(abortIn), .dataValidIn(dataValidIn), .dataIn(dataIn),
    .dataReadyOut(dataReadyOut), .loadingOut(loadingOut),
    .doneOut(doneOut), .errorOut(errorOut),
    .wordCountOut(wordCountOut), .addressIn(addressIn),
    .dataOut(dataOut)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: session flag, word count, memory and valid arrays.
  bit         m_act = 0, m_done = 0, m_err = 0;
  int         m_cnt = 0, m_len = 0;
  logic [3:0] m_mem [D];
  bit         m_vld [D];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act  <= 0;
      m_done <= 0;
      m_err  <= 0;
      m_cnt  <= 0;
      foreach (m_vld[i]) m_vld[i] <= 0;
    end else begin
      m_done <= 0;
      if (m_act) begin
        if (abortIn) begin
          m_act <= 0;
          m_err <= 1;
        end else if (dataValidIn) begin
          m_mem[m_cnt] <= dataIn;
          m_vld[m_cnt] <= 1;
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_len) begin
            m_act  <= 0;
            m_done <= 1;
          end
        end
      end else if (!m_done && startIn) begin
        if (int'(lengthIn) > D) begin
          m_err <= 1;
        end else begin
          foreach (m_vld[i]) m_vld[i] <= 0;
          m_cnt <= 0;
          m_err <= 0;
          m_len <= int'(lengthIn);
          if (lengthIn == 0) m_done <= 1;
          else m_act <= 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp();
    logic [3:0] ed;
    ed = m_vld[addressIn] ? m_mem[addressIn] : 4'b0111;
    chk("m_ready", 32'(dataReadyOut), 32'(m_act));
    chk("m_loading", 32'(loadingOut), 32'(m_act));
    chk("m_done", 32'(doneOut), 32'(m_done));
    chk("m_error", 32'(errorOut), 32'(m_err));
    chk("m_count", 32'(wordCountOut), 32'(m_cnt));
    chk("m_data", 32'(dataOut), 32'(ed));
  endtask

  // Inputs change at posedge+2; model/outputs are compared at negedge.
  task automatic tick();
    addressIn = 4'($urandom);
    @(negedge clk);
    cmp();
    @(posedge clk);
    #2;
  endtask

  task automatic peek(input int a, input logic [3:0] exp);
    addressIn = 4'(a);
    #1;
    chk($sformatf("peek%0d", a), 32'(dataOut), 32'(exp));
  endtask

  task automatic realign();
    @(posedge clk);
    #2;
  endtask

  task automatic run_load(input int len, input int gap,
                          input logic [3:0] w[$]);
    startIn  = 1'b1;
    lengthIn = 5'(len);
    tick();
    startIn = 1'b0;
    chk("load_rise", 32'(loadingOut), 1);
    chk("ready_rise", 32'(dataReadyOut), 1);
    for (int i = 0; i < w.size(); i++) begin
      dataValidIn = 1'b1;
      dataIn      = w[i];
      tick();
      dataValidIn = 1'b0;
      if (i < w.size() - 1) begin
        chk("done_early", 32'(doneOut), 0);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("done_gap", 32'(doneOut), 0);
        end
      end
    end
    chk("done_pulse", 32'(doneOut), 1);
    chk("load_fall", 32'(loadingOut), 0);
    chk("count_end", 32'(wordCountOut), 32'(len));
    tick();
    chk("done_one", 32'(doneOut), 0);
  endtask

  initial begin
    logic [3:0] q[$];
    logic [3:0] full[$];

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk("rst_ready", 32'(dataReadyOut), 0);
    chk("rst_loading", 32'(loadingOut), 0);
    chk("rst_done", 32'(doneOut), 0);
    chk("rst_error", 32'(errorOut), 0);
    chk("rst_count", 32'(wordCountOut), 0);
    for (int a = 0; a < D; a++) peek(a, 4'b0111);
    realign();

    q = '{4'b0000, 4'b0001, 4'b1010};
    run_load(3, 0, q);
    peek(0, 4'b0000); peek(1, 4'b0001);
    peek(2, 4'b1010); peek(3, 4'b0111);
    realign();

    run_load(3, 2, q);
    peek(0, 4'b0000); peek(1, 4'b0001);
    peek(2, 4'b1010); peek(3, 4'b0111);
    realign();

    q = '{4'b0011};
    run_load(1, 0, q);
    peek(0, 4'b0011); peek(1, 4'b0111); peek(2, 4'b0111);
    realign();

    startIn = 1'b1; lengthIn = 5'd17;
    tick();
    startIn = 1'b0;
    chk("len17_err", 32'(errorOut), 1);
    chk("len17_load", 32'(loadingOut), 0);
    tick();
    chk("len17_idle", 32'(loadingOut), 0);
    peek(0, 4'b0011); peek(1, 4'b0111);
    realign();

    for (int i = 0; i < D; i++) full.push_back(4'($urandom));
    run_load(16, 0, full);
    chk("len16_err", 32'(errorOut), 0);
    for (int a = 0; a < D; a++) peek(a, full[a]);
    realign();

    startIn = 1'b1; lengthIn = 5'd0;
    tick();
    startIn = 1'b0;
    chk("len0_done", 32'(doneOut), 1);
    chk("len0_load", 32'(loadingOut), 0);
    tick();
    chk("len0_done_end", 32'(doneOut), 0);
    for (int a = 0; a < D; a++) peek(a, 4'b0111);
    realign();

    startIn = 1'b1; lengthIn = 5'd5;
    tick();
    startIn = 1'b0;
    dataValidIn = 1'b1;
    dataIn = 4'h9; tick();
    dataIn = 4'h5; tick();
    abortIn = 1'b1; dataIn = 4'hF; tick();
    abortIn = 1'b0; dataValidIn = 1'b0;
    chk("abort_err", 32'(errorOut), 1);
    chk("abort_load", 32'(loadingOut), 0);
    chk("abort_count", 32'(wordCountOut), 2);
    peek(0, 4'h9); peek(1, 4'h5); peek(2, 4'b0111);
    realign();

    startIn = 1'b1; lengthIn = 5'd5;
    tick();
    startIn = 1'b0;
    dataValidIn = 1'b1;
    dataIn = 4'h2; tick();
    dataIn = 4'h4; tick();
    dataValidIn = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mrst_load", 32'(loadingOut), 0);
    chk("mrst_ready", 32'(dataReadyOut), 0);
    chk("mrst_count", 32'(wordCountOut), 0);
    chk("mrst_err", 32'(errorOut), 0);
    peek(0, 4'b0111); peek(1, 4'b0111);
    realign();
    reset = 1'b0;
    tick();

    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      startIn     = ($urandom_range(0, 3) == 0);
      lengthIn    = 5'($urandom_range(0, 20));
      abortIn     = ($urandom_range(0, 29) == 0);
      dataValidIn = ($urandom_range(0, 2) != 0);
      dataIn      = 4'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writer-side counterpart of the program ROM. It receives a stream of 4-bit instruction words over a valid/ready handshake and writes them sequentially from address 0 into an internal program memory. A combinational read port with ROM-identical semantics serves the CPU fetch path. Any location not written in the current session reads as CLR (NOP). While a load is in progress, the CPU is held in halt.

Parameters:
ADDR_WIDTH, 8, fetch address width; DEPTH = 2**ADDR_WIDTH words
NOP_WORD, 4'b0111, value returned for unwritten locations (CLR)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
startIn  in  1  request a new load session; sampled only in IDLE
lengthIn  in  ADDR_WIDTH+1  number of words to load (0..DEPTH); sampled with startIn
abortIn  in  1  abandon the session; honoured only in LOAD
dataValidIn  in  1  dataIn holds a valid instruction word
dataIn  in  4  instruction word
dataReadyOut  out  1  loader accepts a word this cycle
loadingOut  out  1  session active; drives CPU halt
doneOut  out  1  one-cycle pulse on successful completion
errorOut  out  1  sticky flag for a bad length or an abort; cleared by the next accepted start
wordCountOut  out  ADDR_WIDTH+1  words written in the current or last session
addressIn  in  ADDR_WIDTH  fetch address
dataOut  out  4  instruction at addressIn (combinational)

Behaviour:
- Storage:
  - mem[DEPTH] x 4 bits, no reset.
  - valid[DEPTH] bits, asynchronously cleared by reset.
  - dataOut = valid[addressIn] ? mem[addressIn] : NOP_WORD, purely combinational.
- Reset values:
  - state = IDLE
  - dataReadyOut = loadingOut = doneOut = errorOut = 0
  - wordCountOut = 0, write pointer = 0
  - all valid bits = 0, so every address reads 4'b0111
- FSM states: IDLE, LOAD, DONE. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs, except addressIn to dataOut.
- IDLE:
  - startIn=1 with lengthIn > DEPTH: set errorOut=1; no other change; stay in IDLE.
  - startIn=1 with lengthIn <= DEPTH: in one cycle, clear all valid bits, pointer=0, wordCountOut=0, errorOut=0. Store the length.
    - Go to DONE if the length is 0; otherwise go to LOAD.
- LOAD:
  - loadingOut=1 and dataReadyOut=1.
  - On each edge where dataValidIn & dataReadyOut:
    - mem[ptr] <= dataIn; valid[ptr] <= 1
    - ptr++, wordCountOut++
  - A word written at edge E is visible on dataOut from E onward (read-after-write after one edge).
  - When the accepted word makes wordCountOut equal the length, go to DONE. No further words are accepted.
  - dataValidIn gaps are allowed; the FSM waits indefinitely.
  - startIn is ignored in LOAD.
  - abortIn=1: go to IDLE and set errorOut=1. Words already written stay valid. abortIn takes priority over a simultaneous data transfer: that word is not written.
- DONE:
  - Lasts exactly one cycle: doneOut=1, loadingOut=0, dataReadyOut=0.
  - Then go to IDLE.
- Latency:
  - startIn sampled at edge T → loadingOut and dataReadyOut high from T+1.
  - Last word accepted at edge E → doneOut high in cycle E..E+1, and loadingOut low in that same cycle.
- Wrap: the pointer never wraps, because the length is capped at DEPTH. A length of DEPTH fills every location.
- Reset mid-session: return immediately to reset values. The whole memory reads NOP.

Test Plan:
- Reset, then sweep addressIn 0..DEPTH-1 → dataOut = 4'b0111 at every address; all status outputs 0.
- start with length=3, stream 4'b0000, 4'b0001, 4'b1010 back-to-back:
  - loadingOut rises 1 cycle after start; doneOut pulses the cycle after the 3rd transfer; wordCountOut = 3.
  - addresses 0/1/2 read 0000/0001/1010; address 3 reads 0111.
- Same load with 2-cycle dataValidIn gaps → identical memory contents; doneOut delayed by exactly the gap cycles.
- Reload with length=1 (4'b0011) after the previous test → address 0 = 0011; addresses 1 and 2 revert to 0111.
- ADDR_WIDTH=4:
  - length=17 → errorOut=1, loadingOut stays 0, memory unchanged.
  - length=16 → all 16 addresses written, doneOut pulses.
  - length=0 → doneOut pulses 1 cycle after start; all addresses read 0111.
- Interrupted sessions:
  - abortIn after 2 of 5 words → IDLE, errorOut=1, addresses 0..1 keep their data, address 2 = 0111.
  - reset asserted mid-load → outputs return to zero asynchronously; all addresses read 0111.
